// File: rtl/masked_inv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// masked_inv_arbiter_pkg
// Shared types and constants for the masked inverter arbiter slice:
//   bv8_t           one byte share
//   inv_tag_t       owner tag carried alongside each inverter slot
//   INV_LATENCY     register stages inside the masked GF(2^8) inverter
//   num_inv_random  fresh random bits consumed per inverter issue
// -----------------------------------------------------------------------------
package masked_inv_arbiter_pkg;

   typedef logic [7:0] bv8_t;

   // Value 3 is never produced; only these three encodings exist.
   typedef enum logic [1:0] {
      TAG_IDLE = 2'd0,
      TAG_S    = 2'd1,
      TAG_K    = 2'd2
   } inv_tag_t;

   localparam int INV_LATENCY = 3;

   // Refresh randomness for the three shared multiplications in the inverter
   // chain: one byte per share pair per multiplication.
   function automatic int num_inv_random(input int num_shares);
      return 8 * ((num_shares * (num_shares - 1)) / 2) * 3;
   endfunction

endpackage

// File: rtl/masked_inv_arbiter_inv_tag_pipe.sv
// -----------------------------------------------------------------------------
// masked_inv_arbiter_inv_tag_pipe
// LATENCY-deep shift register of owner tags that runs in lockstep with the
// masked inverter pipeline. Reset clears every stage to TAG_IDLE, so in-flight
// work is dropped without producing a response.
// Ports:
//   in_clock      clock
//   in_reset      asynchronous active-high reset
//   in_tag        tag of the slot entering the inverter this cycle
//   out_tag_last  tag at stage LATENCY, aligned with the inverter output
//   out_busy      any stage holds a non-IDLE tag
// -----------------------------------------------------------------------------
module masked_inv_arbiter_inv_tag_pipe
   import masked_inv_arbiter_pkg::*;
#(
   parameter int LATENCY = INV_LATENCY
) (
   input  logic     in_clock,
   input  logic     in_reset,
   input  inv_tag_t in_tag,
   output inv_tag_t out_tag_last,
   output logic     out_busy
);

   inv_tag_t tag_q [LATENCY];

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= TAG_IDLE;
         end
      end else begin
         tag_q[0] <= in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            tag_q[i] <= tag_q[i-1];
         end
      end
   end

   assign out_tag_last = tag_q[LATENCY-1];

   always_comb begin
      out_busy = 1'b0;
      for (int i = 0; i < LATENCY; i++) begin
         out_busy = out_busy | (tag_q[i] != TAG_IDLE);
      end
   end

endmodule

// File: rtl/masked_inv_arbiter.sv
// -----------------------------------------------------------------------------
// masked_inv_arbiter
// Shares one pipelined masked GF(2^8) inverter between the round datapath
// (port S) and the key expansion (port K). At most one issue per cycle, each
// gated on a fresh PRNG word; an owner tag travels with every slot and routes
// the result back to the requester that issued it.
// Ports:
//   in_clock, in_reset          clock, asynchronous active-high reset
//   in_s_valid/in_s_a/out_s_ready   round datapath request
//   in_k_valid/in_k_a/out_k_ready   key expansion request
//   in_rnd_valid/in_rnd/out_rnd_consume  PRNG word handshake
//   out_inv_a/out_inv_random    to the inverter inputs
//   in_inv_b                    from the inverter output
//   out_s_valid/out_k_valid/out_b   registered responses (out_b shared)
//   out_busy                    any slot in flight
//   out_stall_count             only with MASKED_INV_ARB_STALL_CNT_EN defined:
//                               saturating count of cycles where a request
//                               was valid but nothing transferred
//
// Handshake: a request transfers in a cycle where valid and ready are both
// high. Ready is combinational (grant AND fresh randomness) and the requester
// must hold valid and data stable until it sees ready. Responses are
// single-cycle pulses that cannot be back-pressured.
// -----------------------------------------------------------------------------
module masked_inv_arbiter
   import masked_inv_arbiter_pkg::*;
#(
   parameter int NUM_SHARES = 2,
   parameter int LATENCY    = INV_LATENCY,
   parameter int NUM_RANDOM = num_inv_random(NUM_SHARES)
) (
   input  logic                    in_clock,
   input  logic                    in_reset,
   input  logic                    in_s_valid,
   input  logic [NUM_SHARES*8-1:0] in_s_a,
   output logic                    out_s_ready,
   input  logic                    in_k_valid,
   input  logic [NUM_SHARES*8-1:0] in_k_a,
   output logic                    out_k_ready,
   input  logic                    in_rnd_valid,
   input  logic [NUM_RANDOM-1:0]   in_rnd,
   output logic                    out_rnd_consume,
   output logic [NUM_SHARES*8-1:0] out_inv_a,
   output logic [NUM_RANDOM-1:0]   out_inv_random,
   input  logic [NUM_SHARES*8-1:0] in_inv_b,
   output logic                    out_s_valid,
   output logic                    out_k_valid,
   output logic [NUM_SHARES*8-1:0] out_b,
   output logic                    out_busy
`ifdef MASKED_INV_ARB_STALL_CNT_EN
   ,
   output logic [15:0]             out_stall_count
`endif
);

   // Round-robin pointer: names the requester that wins the next conflict.
   localparam logic [0:0] RR_S = 1'b0;
   localparam logic [0:0] RR_K = 1'b1;

   logic [0:0] rr_q, rr_d;
   logic       issue_ok, conflict, grant_s, grant_k, xfer_s, xfer_k;
   inv_tag_t   tag_push, tag_last;
   logic       resp_s_q, resp_s_d, resp_k_q, resp_k_d;
   logic [NUM_SHARES*8-1:0] b_q, b_d;

   // Reset also suppresses ready so nothing is accepted while the pipe clears.
   assign issue_ok = in_rnd_valid & ~in_reset;
   assign conflict = in_s_valid & in_k_valid;
   assign grant_s  = in_s_valid & (~in_k_valid | (rr_q == RR_S));
   assign grant_k  = in_k_valid & (~in_s_valid | (rr_q == RR_K));

   assign out_s_ready     = grant_s & issue_ok;
   assign out_k_ready     = grant_k & issue_ok;
   assign xfer_s          = in_s_valid & out_s_ready;
   assign xfer_k          = in_k_valid & out_k_ready;
   assign out_rnd_consume = xfer_s | xfer_k;

   // Selects depend only on valid/grant bits, never on share values; unused
   // slots see all-zero data and randomness.
   always_comb begin
      tag_push       = TAG_IDLE;
      out_inv_a      = '0;
      out_inv_random = '0;
      rr_d           = rr_q;
      if (xfer_s) begin
         tag_push  = TAG_S;
         out_inv_a = in_s_a;
      end else if (xfer_k) begin
         tag_push  = TAG_K;
         out_inv_a = in_k_a;
      end
      if (out_rnd_consume) begin
         out_inv_random = in_rnd;
      end
      // A resolved conflict hands priority to the loser.
      if (conflict && issue_ok) begin
         rr_d = ~rr_q;
      end
   end

   masked_inv_arbiter_inv_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .in_clock     (in_clock),
      .in_reset     (in_reset),
      .in_tag       (tag_push),
      .out_tag_last (tag_last),
      .out_busy     (out_busy)
   );

   assign resp_s_d = (tag_last == TAG_S);
   assign resp_k_d = (tag_last == TAG_K);
   assign b_d      = (tag_last != TAG_IDLE) ? in_inv_b : '0;

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         rr_q     <= RR_S;
         resp_s_q <= 1'b0;
         resp_k_q <= 1'b0;
         b_q      <= '0;
      end else begin
         rr_q     <= rr_d;
         resp_s_q <= resp_s_d;
         resp_k_q <= resp_k_d;
         b_q      <= b_d;
      end
   end

   assign out_s_valid = resp_s_q;
   assign out_k_valid = resp_k_q;
   assign out_b       = b_q;

`ifdef MASKED_INV_ARB_STALL_CNT_EN
   logic [15:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if ((in_s_valid | in_k_valid) && !out_rnd_consume && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge in_clock or posedge in_reset) begin
      if (in_reset) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign out_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_masked_inv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_masked_inv_arbiter
// Directed bench for masked_inv_arbiter. A behavioural 3-stage masked inverter
// stands in for the real one (it re-masks its output so idle slots carry
// non-zero garbage). Expected results are hand-computed AES inverses queued at
// issue time with the issue cycle; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_masked_inv_arbiter;
   import masked_inv_arbiter_pkg::*;

   localparam int NS  = 2;
   localparam int NR  = num_inv_random(NS);
   localparam logic [7:0] S_MASK = 8'h42;
   localparam logic [7:0] K_MASK = 8'h9C;

   logic            clk;
   logic            rst;
   logic            in_s_valid, in_k_valid, in_rnd_valid;
   logic [NS*8-1:0] in_s_a, in_k_a, in_inv_b, out_inv_a, out_b;
   logic [NR-1:0]   in_rnd, out_inv_random;
   logic            out_s_ready, out_k_ready, out_rnd_consume;
   logic            out_s_valid, out_k_valid, out_busy;
`ifdef MASKED_INV_ARB_STALL_CNT_EN
   logic [15:0]     out_stall_count;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   // {issue cycle[15:0], owner {k,s}[1:0], expected unmasked value[7:0]}
   logic [25:0] exp_q[$];

   masked_inv_arbiter u_dut (
      .in_clock        (clk),
      .in_reset        (rst),
      .in_s_valid      (in_s_valid),
      .in_s_a          (in_s_a),
      .out_s_ready     (out_s_ready),
      .in_k_valid      (in_k_valid),
      .in_k_a          (in_k_a),
      .out_k_ready     (out_k_ready),
      .in_rnd_valid    (in_rnd_valid),
      .in_rnd          (in_rnd),
      .out_rnd_consume (out_rnd_consume),
      .out_inv_a       (out_inv_a),
      .out_inv_random  (out_inv_random),
      .in_inv_b        (in_inv_b),
      .out_s_valid     (out_s_valid),
      .out_k_valid     (out_k_valid),
      .out_b           (out_b),
      .out_busy        (out_busy)
`ifdef MASKED_INV_ARB_STALL_CNT_EN
      ,
      .out_stall_count (out_stall_count)
`endif
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc = cyc + 1;

   // ---------------- behavioural inverter ----------------
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 0; i < 254; i++) r = gf_mul(r, a);
      return r;
   endfunction

   logic [15:0] inv_st [3];
   initial for (int i = 0; i < 3; i++) inv_st[i] = '0;

   always @(posedge clk) begin : inv_model
      logic [7:0] u;
      logic [7:0] m;
      u = out_inv_a[7:0] ^ out_inv_a[15:8];
      m = out_inv_random[7:0] ^ 8'h5A;
      inv_st[0] <= {m, gf_inv(u) ^ m};
      inv_st[1] <= inv_st[0];
      inv_st[2] <= inv_st[1];
   end
   assign in_inv_b = inv_st[2];

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin : monitor
      logic [25:0] e;
      if (out_s_valid || out_k_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=%0b%0b required=none (cycle %0d)",
                     out_k_valid, out_s_valid, cyc);
         end else begin
            e = exp_q.pop_front();
            check("resp_owner", {30'd0, out_k_valid, out_s_valid}, {30'd0, e[9:8]});
            check("resp_value", {24'd0, out_b[7:0] ^ out_b[15:8]}, {24'd0, e[7:0]});
            check("resp_latency", cyc, {16'd0, e[25:10]} + 32'd4);
         end
      end else begin
         check("idle_out_b", {16'd0, out_b}, 32'd0);
      end
   end

   // ---------------- driver ----------------
   // One request cycle: drive inputs, check the combinational handshake and
   // inverter-side mux, and queue the expected response for each transfer.
   task automatic drive(input logic sv, input logic [7:0] sb,
                        input logic kv, input logic [7:0] kb,
                        input logic rv,
                        input logic exp_sr, input logic exp_kr,
                        input logic [7:0] res, input logic push);
      logic [15:0] ea;
      logic [NR-1:0] er;
      @(posedge clk);
      #1;
      in_s_valid   = sv;
      in_s_a       = {S_MASK, sb ^ S_MASK};
      in_k_valid   = kv;
      in_k_a       = {K_MASK, kb ^ K_MASK};
      in_rnd_valid = rv;
      in_rnd       = NR'($urandom());
      #1;
      ea = exp_sr ? {S_MASK, sb ^ S_MASK} : (exp_kr ? {K_MASK, kb ^ K_MASK} : 16'h0000);
      er = (exp_sr || exp_kr) ? in_rnd : '0;
      check("s_ready", {31'd0, out_s_ready}, {31'd0, exp_sr});
      check("k_ready", {31'd0, out_k_ready}, {31'd0, exp_kr});
      check("rnd_consume", {31'd0, out_rnd_consume}, {31'd0, exp_sr | exp_kr});
      check("inv_a", {16'd0, out_inv_a}, {16'd0, ea});
      check("inv_random", {8'd0, out_inv_random}, {8'd0, er});
      if (push && exp_sr) exp_q.push_back({cyc[15:0], 2'b01, res});
      if (push && exp_kr) exp_q.push_back({cyc[15:0], 2'b10, res});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst          = 1'b1;
      in_s_valid   = 1'b1;
      in_s_a       = '0;
      in_k_valid   = 1'b1;
      in_k_a       = '0;
      in_rnd_valid = 1'b1;
      in_rnd       = '0;
      #12;
      check("rst_s_ready", {31'd0, out_s_ready}, 32'd0);
      check("rst_k_ready", {31'd0, out_k_ready}, 32'd0);
      check("rst_consume", {31'd0, out_rnd_consume}, 32'd0);
      check("rst_s_valid", {31'd0, out_s_valid}, 32'd0);
      check("rst_k_valid", {31'd0, out_k_valid}, 32'd0);
      check("rst_out_b", {16'd0, out_b}, 32'd0);
      check("rst_busy", {31'd0, out_busy}, 32'd0);
      @(posedge clk);
      #1;
      in_s_valid = 1'b0;
      in_k_valid = 1'b0;
      rst        = 1'b0;

      // Single S request: 0x53 as shares (0x11, 0x42) -> 0xCA four cycles later.
      drive(1'b1, 8'h53, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hCA, 1'b1);
      idle(6);

      // Both valid: alternate S,K,S,K,S,K starting with S.
      drive(1'b1, 8'h53, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 8'hCA, 1'b1);
      drive(1'b1, 8'h02, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
      drive(1'b1, 8'h02, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h8D, 1'b1);
      drive(1'b1, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
      drive(1'b1, 8'h03, 1'b1, 8'h53, 1'b1, 1'b1, 1'b0, 8'hF6, 1'b1);
      drive(1'b1, 8'h01, 1'b1, 8'h53, 1'b1, 1'b0, 1'b1, 8'hCA, 1'b1);
      drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h01, 1'b1);
      idle(6);

      // K stream with a PRNG bubble, then 0x00 and 0x01 through K.
      drive(1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h8D, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'hF6, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1);
      idle(6);

      // Three slots in flight, then asynchronous reset mid-cycle.
      drive(1'b1, 8'h53, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
      @(posedge clk);
      #1;
      check("busy_in_flight", {31'd0, out_busy}, 32'd1);
      #1;
      rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, out_busy}, 32'd0);
      check("arst_s_ready", {31'd0, out_s_ready}, 32'd0);
      check("arst_consume", {31'd0, out_rnd_consume}, 32'd0);
      check("arst_s_valid", {31'd0, out_s_valid}, 32'd0);
      check("arst_out_b", {16'd0, out_b}, 32'd0);
      in_s_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(8);
      check("post_rst_busy", {31'd0, out_busy}, 32'd0);

      // Conflict starved of randomness: no ready, pointer stays on S.
      for (int i = 0; i < 5; i++)
         drive(1'b1, 8'h53, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h53, 1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 8'hCA, 1'b1);
`ifdef MASKED_INV_ARB_STALL_CNT_EN
      check("stall_count", {16'd0, out_stall_count}, 32'd5);
`endif
      drive(1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h8D, 1'b1);
      idle(8);
`ifdef MASKED_INV_ARB_STALL_CNT_EN
      check("stall_count_hold", {16'd0, out_stall_count}, 32'd5);
`endif

      check("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
